// File: rtl/tri_load_pkg.sv
// Shared definitions for the triangle serial-to-parallel load controller.
package tri_load_pkg;

  localparam int unsigned FRAME_BITS = 144;
  localparam int unsigned TRI_CNT_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/frame_gap_timer.sv
// Counts consecutive idle cycles inside a frame; expired fires on the
// GAP_TIMEOUT-th idle cycle and the counter restarts from zero.
module frame_gap_timer #(
  parameter int unsigned GAP_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int unsigned GW = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;

  logic [GW-1:0] gap;

  assign expired = run && !clr && (gap == GW'(GAP_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr || expired) begin
      gap <= '0;
    end else if (run) begin
      gap <= gap + GW'(1);
    end
  end

endmodule

// File: rtl/tri_load_ctrl.sv
// Sequences the 144-bit triangle SIPO: bit counting, shift gating, framing
// error detection and valid/ready handoff to the rasterizer front end.
module tri_load_ctrl
  import tri_load_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned GAP_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 bit_valid,
  input  logic                 sipo_done,
  output logic [CNT_W-1:0]     count,
  output logic                 shift_en,
  output logic                 sipo_valid_data,
  output logic                 tri_valid,
  input  logic                 tri_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic [TRI_CNT_W-1:0] tri_count
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);

  state_t state;
  logic   start_pend;
  logic   first_hold;
  logic   gap_clr;
  logic   gap_run;
  logic   gap_expired;

  // Gap timer only accumulates idle cycles while collecting bits.
  assign gap_clr = (state != S_SHIFT) || bit_valid || start;
  assign gap_run = (state == S_SHIFT) && !bit_valid;

  frame_gap_timer #(
    .GAP_TIMEOUT(GAP_TIMEOUT)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (gap_clr),
    .run    (gap_run),
    .expired(gap_expired)
  );

  // A start-cycle bit in IDLE is bit 0 of the new frame.
  assign shift_en = !rst && bit_valid &&
                    ((state == S_SHIFT) || ((state == S_IDLE) && start));

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      count           <= '0;
      sipo_valid_data <= 1'b0;
      tri_valid       <= 1'b0;
      busy            <= 1'b0;
      frame_err       <= 1'b0;
      tri_count       <= '0;
      start_pend      <= 1'b0;
      first_hold      <= 1'b0;
    end else begin
      frame_err       <= 1'b0;
      sipo_valid_data <= 1'b0;
      case (state)
        S_IDLE: begin
          count <= '0;
          if (start) begin
            state           <= S_SHIFT;
            busy            <= 1'b1;
            sipo_valid_data <= 1'b1;
            count           <= bit_valid ? CNT_W'(1) : '0;
          end
        end
        S_SHIFT: begin
          // Restart outranks both completion and gap expiry.
          if (start) begin
            frame_err       <= 1'b1;
            sipo_valid_data <= 1'b1;
            count           <= bit_valid ? CNT_W'(1) : '0;
          end else if (bit_valid) begin
            if (count == LAST_IDX) begin
              state      <= S_HOLD;
              tri_valid  <= 1'b1;
              first_hold <= 1'b1;
            end else begin
              count <= count + CNT_W'(1);
            end
          end else if (gap_expired) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
            busy      <= 1'b0;
            count     <= '0;
          end
        end
        S_HOLD: begin
          first_hold <= 1'b0;
          frame_err  <= (first_hold && !sipo_done) || bit_valid;
          if (tri_valid && tri_ready) begin
            tri_count  <= tri_count + TRI_CNT_W'(1);
            tri_valid  <= 1'b0;
            start_pend <= 1'b0;
            count      <= '0;
            if (start_pend || start) begin
              state           <= S_SHIFT;
              sipo_valid_data <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else if (start) begin
            start_pend <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          count      <= '0;
          tri_valid  <= 1'b0;
          busy       <= 1'b0;
          start_pend <= 1'b0;
          first_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tri_load_ctrl.sv
// Bench for tri_load_ctrl: directed frame scenarios plus random traffic,
// every output compared each cycle against a frame-level reference model.
module tb_tri_load_ctrl;

  localparam int unsigned FB = 144;
  localparam int unsigned GT = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        bit_valid = 1'b0;
  logic        sipo_done = 1'b0;
  logic        tri_ready = 1'b0;
  logic [7:0]  count;
  logic        shift_en;
  logic        sipo_valid_data;
  logic        tri_valid;
  logic        busy;
  logic        frame_err;
  logic [15:0] tri_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame-level bookkeeping
  bit          m_in_frame = 1'b0;
  bit          m_waiting  = 1'b0;
  bit          m_first    = 1'b0;
  bit          m_pend     = 1'b0;
  bit          m_err      = 1'b0;
  bit          m_rearm    = 1'b0;
  int          m_nbits    = 0;
  int          m_idle     = 0;
  int unsigned m_handed   = 0;

  tri_load_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .bit_valid      (bit_valid),
    .sipo_done      (sipo_done),
    .count          (count),
    .shift_en       (shift_en),
    .sipo_valid_data(sipo_valid_data),
    .tri_valid      (tri_valid),
    .tri_ready      (tri_ready),
    .busy           (busy),
    .frame_err      (frame_err),
    .tri_count      (tri_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit s, input bit bv,
                                     input bit d, input bit rdy);
    m_err   = 1'b0;
    m_rearm = 1'b0;
    if (r) begin
      m_in_frame = 1'b0; m_waiting = 1'b0; m_first = 1'b0; m_pend = 1'b0;
      m_nbits = 0; m_idle = 0; m_handed = 0;
    end else if (m_waiting) begin
      if ((m_first && !d) || bv) m_err = 1'b1;
      m_first = 1'b0;
      if (s) m_pend = 1'b1;
      if (rdy) begin
        m_handed++;
        m_waiting = 1'b0;
        if (m_pend) begin
          m_in_frame = 1'b1; m_nbits = 0; m_idle = 0; m_rearm = 1'b1;
        end
        m_pend = 1'b0;
      end
    end else if (m_in_frame) begin
      if (s) begin
        m_err = 1'b1; m_rearm = 1'b1; m_idle = 0;
        m_nbits = bv ? 1 : 0;
      end else if (bv) begin
        m_idle = 0;
        m_nbits++;
        if (m_nbits == int'(FB)) begin
          m_in_frame = 1'b0; m_waiting = 1'b1; m_first = 1'b1;
        end
      end else begin
        m_idle++;
        if (m_idle == int'(GT)) begin
          m_err = 1'b1; m_in_frame = 1'b0; m_nbits = 0; m_idle = 0;
        end
      end
    end else if (s) begin
      m_in_frame = 1'b1; m_rearm = 1'b1; m_idle = 0;
      m_nbits = bv ? 1 : 0;
    end
  endfunction

  // The SIPO reports completion in the first cycle a triangle is waiting
  function automatic bit dn();
    return m_waiting && m_first;
  endfunction

  task automatic cyc(input bit r, input bit s, input bit bv, input bit d, input bit rdy);
    bit          exp_se;
    int unsigned exp_cnt;
    @(negedge clk);
    rst = r; start = s; bit_valid = bv; sipo_done = d; tri_ready = rdy;
    #1;
    exp_se  = !r && bv && (m_in_frame || (!m_waiting && s));
    exp_cnt = m_waiting ? FB - 1 : (m_in_frame ? int'(m_nbits) : 0);
    check("count",           32'(count),           32'(exp_cnt));
    check("shift_en",        32'(shift_en),        32'(exp_se));
    check("tri_valid",       32'(tri_valid),       32'(m_waiting));
    check("busy",            32'(busy),            32'(m_in_frame || m_waiting));
    check("frame_err",       32'(frame_err),       32'(m_err));
    check("sipo_valid_data", 32'(sipo_valid_data), 32'(m_rearm));
    check("tri_count",       32'(tri_count),       32'(m_handed % 65536));
    model_step(r, s, bv, d, rdy);
  endtask

  task automatic bits(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, dn(), 1'b0);
  endtask

  initial begin
    bit r, s, bv, d, rdy;
    @(posedge clk);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full frame, handoff delayed by a stalled rasterizer
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bits(143);
    repeat (10) cyc(1'b0, 1'b0, 1'b0, dn(), 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Mid-frame restart, then a clean frame
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bits(49);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bits(144);
    cyc(1'b0, 1'b0, 1'b0, dn(), 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Gap timeout after 20 bits; stray bits in IDLE are ignored
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bits(19);
    repeat (GT + 5) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Start while holding, delayed ready, then back-to-back frames
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bits(143);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    bits(144);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    bits(144);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Missing completion pulse, overrun bit in HOLD
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bits(143);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset mid-frame with a bit pending
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bits(99);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(999) == 0);
      s   = ($urandom_range(149) == 0);
      bv  = ($urandom_range(3) != 0);
      d   = dn() && ($urandom_range(7) != 0);
      rdy = ($urandom_range(2) == 0);
      if (m_waiting) bv = ($urandom_range(9) == 0);
      cyc(r, s, bv, d, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
